// File: rtl/i2c_single_reg_master.sv
// i2c_single_reg_master
// Single-byte I2C initiator. Each accepted command runs one bus transaction:
// START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP, and then
// reports the result on the response interface. SCL/SDA are open-drain.
// Each bit slot is four quarters of PRESCALE clocks. While SCL is released,
// the quarter counter waits for the filtered SCL to read high, which honours
// clock stretching by the target.
module i2c_single_reg_master #(
  parameter int PRESCALE   = 250,
  parameter int FILTER_LEN = 4,
  parameter int DEBUG      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_read,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy
);

  localparam int            QW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [QW-1:0] QLAST = QW'(PRESCALE - 1);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_START    = 4'd1;
  localparam logic [3:0] ST_ADDR     = 4'd2;
  localparam logic [3:0] ST_ADDR_ACK = 4'd3;
  localparam logic [3:0] ST_WRITE    = 4'd4;
  localparam logic [3:0] ST_WR_ACK   = 4'd5;
  localparam logic [3:0] ST_READ     = 4'd6;
  localparam logic [3:0] ST_RD_NACK  = 4'd7;
  localparam logic [3:0] ST_STOP     = 4'd8;
  localparam logic [3:0] ST_DONE     = 4'd9;

  logic [3:0]            state;
  logic [1:0]            q;
  logic [QW-1:0]         qcnt;
  logic [2:0]            bit_cnt;
  logic [7:0]            addr_byte;
  logic [7:0]            wdata_r;
  logic [7:0]            rx_shift;
  logic                  nack_r;
  logic                  sample_bit;
  logic [FILTER_LEN-1:0] scl_sr;
  logic [FILTER_LEN-1:0] sda_sr;
  logic                  scl_f;
  logic                  sda_f;
  logic                  hold;
  logic                  q_end;
  logic                  slot_end;
  logic                  sample_now;

  // Debug tracing is a simulation-side concern; no hardware is generated for it.
  if (DEBUG != 0) begin : g_debug
  end

  // Glitch filters: the filtered level follows the pad only once every tap agrees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_f  <= 1'b1;
      sda_f  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[FILTER_LEN-2:0], scl_i};
      sda_sr <= {sda_sr[FILTER_LEN-2:0], sda_i};
      if (&scl_sr)       scl_f <= 1'b1;
      else if (~|scl_sr) scl_f <= 1'b0;
      if (&sda_sr)       sda_f <= 1'b1;
      else if (~|sda_sr) sda_f <= 1'b0;
    end
  end

  // A released SCL that still reads low means the target is stretching the clock.
  assign hold       = scl_o && !scl_f;
  assign q_end      = !hold && (qcnt == QLAST);
  assign slot_end   = q_end && (q == 2'd3);
  assign sample_now = q_end && (q == 2'd2);

  // Pad drive levels derived from the current state and quarter.
  always_comb begin
    scl_o = 1'b1;
    sda_o = 1'b1;
    case (state)
      ST_START: begin
        scl_o = (q != 2'd3);
        sda_o = (q == 2'd0);
      end
      ST_ADDR: begin
        scl_o = q[1];
        sda_o = addr_byte[bit_cnt];
      end
      ST_WRITE: begin
        scl_o = q[1];
        sda_o = wdata_r[bit_cnt];
      end
      ST_ADDR_ACK, ST_WR_ACK, ST_READ, ST_RD_NACK: begin
        scl_o = q[1];
      end
      ST_STOP: begin
        scl_o = (q != 2'd0);
        sda_o = (q == 2'd3);
      end
      default: begin
        scl_o = 1'b1;
        sda_o = 1'b1;
      end
    endcase
  end

  assign scl_t     = scl_o;
  assign sda_t     = sda_o;
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_DONE);

  // Quarter timing: PRESCALE clocks per quarter, frozen while SCL is being stretched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qcnt <= '0;
      q    <= 2'd0;
    end else if (state == ST_IDLE || state == ST_DONE) begin
      qcnt <= '0;
      q    <= 2'd0;
    end else if (!hold) begin
      if (qcnt == QLAST) begin
        qcnt <= '0;
        q    <= q + 2'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end
    end
  end

  // Transaction sequencing, SDA sampling and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      addr_byte  <= 8'h00;
      wdata_r    <= 8'h00;
      rx_shift   <= 8'h00;
      nack_r     <= 1'b0;
      sample_bit <= 1'b1;
      rsp_data   <= 8'h00;
      rsp_nack   <= 1'b0;
    end else begin
      if (sample_now) sample_bit <= sda_f;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_byte <= {cmd_addr, cmd_read};
            wdata_r   <= cmd_wdata;
            nack_r    <= 1'b0;
            rx_shift  <= 8'h00;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (slot_end) begin
            bit_cnt <= 3'd7;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (slot_end) begin
            if (bit_cnt == 3'd0) state <= ST_ADDR_ACK;
            else                 bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_ADDR_ACK: begin
          if (slot_end) begin
            bit_cnt <= 3'd7;
            if (sample_bit) begin
              nack_r <= 1'b1;
              state  <= ST_STOP;
            end else if (addr_byte[0]) begin
              state <= ST_READ;
            end else begin
              state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (slot_end) begin
            if (bit_cnt == 3'd0) state <= ST_WR_ACK;
            else                 bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_WR_ACK: begin
          if (slot_end) begin
            nack_r <= sample_bit;
            state  <= ST_STOP;
          end
        end
        ST_READ: begin
          if (sample_now) rx_shift <= {rx_shift[6:0], sda_f};
          if (slot_end) begin
            if (bit_cnt == 3'd0) state <= ST_RD_NACK;
            else                 bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_RD_NACK: begin
          if (slot_end) state <= ST_STOP;
        end
        ST_STOP: begin
          if (slot_end) begin
            rsp_nack <= nack_r;
            rsp_data <= (addr_byte[0] && !nack_r) ? rx_shift : 8'h00;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_single_reg_master.sv
// tb_i2c_single_reg_master
// Drives directed commands into the I2C initiator against a behavioural
// single-register target at 0x70 on an open-drain bus. Expected responses are
// queued when a command is issued and popped by an independent monitor.
module tb_i2c_single_reg_master;

  localparam logic [6:0] TGT_ADDR = 7'h70;
  localparam int T_IDLE = 0, T_ADDR = 1, T_AACK = 2, T_RX = 3,
                 T_DACK = 4, T_TX = 5, T_MACK = 6, T_IGN = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_o, scl_t, sda_o, sda_t;
  logic       cmd_valid, cmd_ready, cmd_read;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_nack, busy;
  logic [7:0] rsp_data;

  logic       tgt_scl = 1'b1;
  logic       tgt_sda = 1'b1;
  wire        scl_bus = scl_o & tgt_scl;
  wire        sda_bus = sda_o & tgt_sda;

  int         checks = 0;
  int         passes = 0;
  int         rsp_seen = 0;
  int         rsp_target = 0;
  int         busy_cycles = 0;
  int         last_busy = 0;
  logic [8:0] exp_q[$];
  logic       stretch_en = 1'b0;

  always #5 clk = ~clk;

  i2c_single_reg_master #(.PRESCALE(4), .FILTER_LEN(4), .DEBUG(0)) dut (
    .clk(clk), .rst(rst),
    .scl_i(scl_bus), .scl_o(scl_o), .scl_t(scl_t),
    .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_read(cmd_read), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack), .busy(busy)
  );

  // Behavioural target state
  int         t_state = T_IDLE;
  int         t_bits = 0;
  int         stop_cnt = 0;
  int         mnack_cnt = 0;
  int         stretch_cnt = 0;
  logic [7:0] t_shift = 8'h00;
  logic [7:0] tx_byte = 8'h00;
  logic [7:0] tgt_data = 8'h00;
  logic       t_rw = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;

  // Single-register target: ACKs its own address, stores one written byte, returns it on reads.
  always @(posedge clk) begin
    prev_scl <= scl_bus;
    prev_sda <= sda_bus;
    if (stretch_cnt != 0) begin
      stretch_cnt <= stretch_cnt - 1;
      if (stretch_cnt == 1) tgt_scl <= 1'b1;
    end
    if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
      t_state <= T_ADDR;
      t_bits  <= 0;
      tgt_sda <= 1'b1;
    end else if (prev_scl && scl_bus && !prev_sda && sda_bus) begin
      t_state  <= T_IDLE;
      tgt_sda  <= 1'b1;
      stop_cnt <= stop_cnt + 1;
    end else if (!prev_scl && scl_bus) begin
      case (t_state)
        T_ADDR, T_RX: begin
          t_shift <= {t_shift[6:0], sda_bus};
          t_bits  <= t_bits + 1;
        end
        T_MACK: if (sda_bus) mnack_cnt <= mnack_cnt + 1;
        default: ;
      endcase
    end else if (prev_scl && !scl_bus) begin
      case (t_state)
        T_ADDR: if (t_bits == 8) begin
          if (t_shift[7:1] == TGT_ADDR) begin
            tgt_sda <= 1'b0;
            t_rw    <= t_shift[0];
            t_state <= T_AACK;
          end else begin
            t_state <= T_IGN;
          end
        end
        T_AACK: if (t_rw) begin
          tx_byte <= tgt_data;
          tgt_sda <= tgt_data[7];
          t_bits  <= 1;
          t_state <= T_TX;
        end else begin
          tgt_sda <= 1'b1;
          t_bits  <= 0;
          t_state <= T_RX;
        end
        T_RX: if (t_bits == 8) begin
          tgt_data <= t_shift;
          tgt_sda  <= 1'b0;
          t_state  <= T_DACK;
        end
        T_DACK: begin
          tgt_sda <= 1'b1;
          t_state <= T_IGN;
        end
        T_TX: if (t_bits == 8) begin
          tgt_sda <= 1'b1;
          t_state <= T_MACK;
        end else begin
          tgt_sda <= tx_byte[7 - t_bits];
          t_bits  <= t_bits + 1;
          if (stretch_en && t_bits == 4) begin
            tgt_scl     <= 1'b0;
            stretch_cnt <= 1000;
          end
        end
        T_MACK: t_state <= T_IGN;
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
  endtask

  // Issue one command; when pushExp is set the expected response joins the scoreboard.
  task automatic applyStimulus(input logic [6:0] a, input logic rd, input logic [7:0] wd,
                               input logic [7:0] expData, input logic expNack, input logic pushExp);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) checkOutput("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_addr  = a;
    cmd_read  = rd;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    if (pushExp) begin
      exp_q.push_back({expData, expNack});
      rsp_target++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone();
    int guard = 0;
    while (rsp_seen < rsp_target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (rsp_seen < rsp_target) checkOutput("rsp_timeout", rsp_seen, rsp_target);
  endtask

  // Monitor: pops the scoreboard on every response and tracks busy length per transaction.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (rsp_valid) begin
        rsp_seen++;
        last_busy   = busy_cycles;
        busy_cycles = 0;
        checkOutput("rsp_busy", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, e[8:1]});
          checkOutput("rsp_nack", {31'd0, rsp_nack}, {31'd0, e[0]});
        end
      end
    end
  end

  initial begin
    int stops0, nacks0, base_busy, delta, accepts, gap, guard;
    logic seen_done;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = 7'h00;
    cmd_read = 1'b0;
    cmd_wdata = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_scl_o", {31'd0, scl_o}, 32'd1);
    checkOutput("rst_sda_o", {31'd0, sda_o}, 32'd1);
    checkOutput("rst_scl_t", {31'd0, scl_t}, 32'd1);
    checkOutput("rst_sda_t", {31'd0, sda_t}, 32'd1);
    checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    checkOutput("rst_rsp_nack", {31'd0, rsp_nack}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] write 0xA5 to 0x70");
    stops0 = stop_cnt;
    applyStimulus(7'h70, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b1);
    waitDone();
    checkOutput("wr_tgt_data", {24'd0, tgt_data}, 32'hA5);
    checkOutput("wr_stop", stop_cnt - stops0, 32'd1);

    $display("[TB] read 0x70");
    stops0 = stop_cnt;
    nacks0 = mnack_cnt;
    applyStimulus(7'h70, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b1);
    waitDone();
    base_busy = last_busy;
    checkOutput("rd_master_nack", mnack_cnt - nacks0, 32'd1);
    checkOutput("rd_stop", stop_cnt - stops0, 32'd1);

    $display("[TB] write to absent 0x71");
    stops0 = stop_cnt;
    applyStimulus(7'h71, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b1);
    waitDone();
    checkOutput("nack_tgt_data", {24'd0, tgt_data}, 32'hA5);
    checkOutput("nack_stop", stop_cnt - stops0, 32'd1);

    $display("[TB] read from absent 0x71");
    applyStimulus(7'h71, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
    waitDone();

    $display("[TB] stretched read");
    applyStimulus(7'h70, 1'b0, 8'h6C, 8'h00, 1'b0, 1'b1);
    waitDone();
    checkOutput("wr2_tgt_data", {24'd0, tgt_data}, 32'h6C);
    stretch_en = 1'b1;
    applyStimulus(7'h70, 1'b1, 8'h00, 8'h6C, 1'b0, 1'b1);
    waitDone();
    stretch_en = 1'b0;
    delta = last_busy - base_busy;
    checkOutput("stretch_wait", {31'd0, (delta >= 900 && delta <= 1100)}, 32'd1);

    $display("[TB] reset during write");
    applyStimulus(7'h70, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    repeat (260) @(negedge clk);
    checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("abort_scl_o", {31'd0, scl_o}, 32'd1);
    checkOutput("abort_sda_o", {31'd0, sda_o}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("abort_tgt_data", {24'd0, tgt_data}, 32'h6C);
    applyStimulus(7'h70, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b1);
    waitDone();
    checkOutput("post_abort_data", {24'd0, tgt_data}, 32'h3C);

    $display("[TB] cmd_valid held across transfers");
    @(negedge clk);
    cmd_addr  = 7'h70;
    cmd_read  = 1'b1;
    cmd_wdata = 8'h00;
    cmd_valid = 1'b1;
    exp_q.push_back({8'h3C, 1'b0});
    exp_q.push_back({8'h3C, 1'b0});
    rsp_target += 2;
    accepts = 0;
    gap = 0;
    guard = 0;
    seen_done = 1'b0;
    while (accepts < 2 && guard < 5000) begin
      @(posedge clk);
      if (cmd_ready) accepts++;
      @(negedge clk);
      if (rsp_valid) seen_done = 1'b1;
      else if (seen_done && !busy) gap++;
      guard++;
    end
    cmd_valid = 1'b0;
    waitDone();
    checkOutput("held_accepts", accepts, 32'd2);
    checkOutput("held_gap", gap, 32'd1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
